lsu_mem_port: RTL and testbench

Load/store initiator that drives the byte-addressed data SRAM port (4-bit byte write enable, 16-bit byte address, 32-bit write data, combinational 32-bit read data; the SRAM writes on the falling clock edge).
- Accepts one RV32I load or store per handshake from the pipeline MEM stage.
- Registers and holds the SRAM port signals for exactly one access cycle.
- Returns load data byte-selected and sign- or zero-extended, plus an error flag.
- Owns all legality checking, so the SRAM never sees an illegal write.

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_mem_port_load_extend.sv | 21 ++
 rtl/lsu_mem_port.sv | 92 +++++++++
 tb/tb_lsu_mem_port.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, byte enables, FSM states and legality helpers
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  function automatic logic req_legal(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] addr_lo, input logic allow_misaligned);
    logic f3_ok;
    logic aligned;
    f3_ok   = 1'b0;
    aligned = 1'b1;
    case (funct3)
      F3_B:  f3_ok = 1'b1;
      F3_H:  begin f3_ok = 1'b1; aligned = !addr_lo[0];      end
      F3_W:  begin f3_ok = 1'b1; aligned = (addr_lo == 2'b00); end
      F3_BU: f3_ok = !we;
      F3_HU: begin f3_ok = !we;  aligned = !addr_lo[0];      end
      default: f3_ok = 1'b0;
    endcase
    return f3_ok && (allow_misaligned || aligned);
  endfunction

  // Only meaningful for stores that already passed req_legal.
  function automatic logic [3:0] store_be(input logic [2:0] funct3);
    case (funct3)
      F3_B:    return BE_B;
      F3_H:    return BE_H;
      default: return BE_W;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_port_load_extend.sv
// rtl/lsu_mem_port_load_extend.sv - byte/halfword select and sign/zero extension of raw load data
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (funct3)
      F3_B:    data = {{24{raw[7]}}, raw[7:0]};
      F3_H:    data = {{16{raw[15]}}, raw[15:0]};
      F3_BU:   data = {24'd0, raw[7:0]};
      F3_HU:   data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - load/store initiator driving a byte-addressed SRAM for one cycle per access
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int ADDR_W           = 16,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [3:0]        mem_w_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t      state, state_next;
  logic [2:0]  funct3_q;
  logic        we_q;
  logic        accept;
  logic        legal;
  logic [31:0] ext_data;

  assign req_ready  = !rst && ((state == S_IDLE) || (state == S_RESP && resp_ready));
  assign accept     = req_valid && req_ready;
  assign legal      = req_legal(req_we, req_funct3, req_addr[1:0], ALLOW_MISALIGNED);
  assign resp_valid = (state == S_RESP);

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (mem_rdata),
    .data   (ext_data)
  );

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) state_next = legal ? S_ACCESS : S_RESP;
      end
      S_ACCESS: state_next = S_RESP;
      S_RESP: begin
        if (accept)          state_next = legal ? S_ACCESS : S_RESP;
        else if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      mem_w_en   <= 4'd0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      funct3_q   <= 3'd0;
      we_q       <= 1'b0;
    end else begin
      state <= state_next;
      if (state == S_ACCESS) begin
        // The SRAM read/write already happened at the mid-cycle falling edge.
        resp_rdata <= we_q ? 32'd0 : ext_data;
        resp_err   <= 1'b0;
        mem_w_en   <= 4'd0;
      end else if (accept) begin
        if (legal) begin
          mem_addr  <= req_addr;
          mem_wdata <= req_wdata;
          mem_w_en  <= req_we ? store_be(req_funct3) : 4'd0;
          funct3_q  <= req_funct3;
          we_q      <= req_we;
        end else begin
          mem_w_en   <= 4'd0;
          resp_err   <= 1'b1;
          resp_rdata <= 32'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// tb/tb_lsu_mem_port.sv - randomized self-checking bench with SRAM models and a byte-array reference
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [15:0] req_addr = 16'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_ready = 1'b1;
  logic [1:0]  req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata [2];
  logic [3:0]  mem_w_en [2];
  logic [15:0] mem_addr [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];

  logic [7:0]  sram    [2][65536];
  logic [7:0]  ref_mem [2][65536];
  bit          mem_init = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Instance 0 allows misaligned accesses, instance 1 does not.
  lsu_mem_port #(.ADDR_W(16), .ALLOW_MISALIGNED(1'b1)) dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_w_en(mem_w_en[0]), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  lsu_mem_port #(.ADDR_W(16), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_w_en(mem_w_en[1]), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  assign mem_rdata[0] = {sram[0][mem_addr[0]+16'd3], sram[0][mem_addr[0]+16'd2],
                         sram[0][mem_addr[0]+16'd1], sram[0][mem_addr[0]]};
  assign mem_rdata[1] = {sram[1][mem_addr[1]+16'd3], sram[1][mem_addr[1]+16'd2],
                         sram[1][mem_addr[1]+16'd1], sram[1][mem_addr[1]]};

  function automatic logic [7:0] init_byte(input int g, input int a);
    return 8'(a * 37 + g * 11 + 5);
  endfunction

  always @(negedge clk) begin
    if (!mem_init) begin
      for (int g = 0; g < 2; g++)
        for (int a = 0; a < 65536; a++) sram[g][a] = init_byte(g, a);
      mem_init = 1'b1;
    end else begin
      for (int g = 0; g < 2; g++)
        for (int i = 0; i < 4; i++)
          if (mem_w_en[g][i]) sram[g][mem_addr[g] + 16'(i)] = mem_wdata[g][8*i +: 8];
    end
  end

  function automatic logic [31:0] sram_word(input int w, input logic [15:0] a);
    return {sram[w][a+16'd3], sram[w][a+16'd2], sram[w][a+16'd1], sram[w][a]};
  endfunction

  function automatic logic [31:0] ref_word(input int w, input logic [15:0] a);
    return {ref_mem[w][a+16'd3], ref_mem[w][a+16'd2], ref_mem[w][a+16'd1], ref_mem[w][a]};
  endfunction

  task automatic run_op(input int w, input logic we, input logic [2:0] f3,
                        input logic [15:0] addr, input logic [31:0] wdata);
    int nb, lat, wen_cnt;
    logic legal, got;
    logic [31:0] exp_rd;
    logic [3:0] exp_be, wen_seen;
    nb = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = (we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
            && (w == 0 || (int'(addr) % nb) == 0);
    exp_rd = 32'd0;
    exp_be = 4'd0;
    if (legal && !we) begin
      for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = ref_mem[w][addr + 16'(i)];
      if (!f3[2] && nb < 4 && exp_rd[8*nb-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*nb));
    end
    if (legal && we) begin
      exp_be = 4'((1 << nb) - 1);
      for (int i = 0; i < nb; i++) ref_mem[w][addr + 16'(i)] = wdata[8*i +: 8];
    end
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid[w] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); got = req_ready[w];
      @(posedge clk);
    end
    #1 req_valid[w] = 1'b0;
    checks++;
    if (!got) begin errors++; $display("FAIL accept w=%0d: req_ready never seen, required 1", w); end
    lat = 1; wen_cnt = 0; wen_seen = 4'd0;
    while (!resp_valid[w] && lat < 8) begin
      if (mem_w_en[w] != 4'd0) begin wen_cnt++; wen_seen = mem_w_en[w]; end
      @(posedge clk); #1 lat++;
    end
    if (mem_w_en[w] != 4'd0) wen_cnt++;
    checks++;
    if (lat !== (legal ? 2 : 1)) begin
      errors++; $display("FAIL latency w=%0d f3=%0d addr=%h: got %0d required %0d", w, f3, addr, lat, legal ? 2 : 1);
    end
    checks++;
    if (resp_err[w] !== !legal) begin
      errors++; $display("FAIL resp_err w=%0d f3=%0d addr=%h: got %b required %b", w, f3, addr, resp_err[w], !legal);
    end
    checks++;
    if (resp_rdata[w] !== exp_rd) begin
      errors++; $display("FAIL resp_rdata w=%0d f3=%0d addr=%h: got %h required %h", w, f3, addr, resp_rdata[w], exp_rd);
    end
    checks++;
    if (wen_cnt !== ((legal && we) ? 1 : 0)) begin
      errors++; $display("FAIL wen_cycles w=%0d f3=%0d addr=%h: got %0d required %0d", w, f3, addr, wen_cnt, (legal && we) ? 1 : 0);
    end
    if (legal && we) begin
      checks++;
      if (wen_seen !== exp_be) begin
        errors++; $display("FAIL mem_w_en w=%0d f3=%0d: got %b required %b", w, f3, wen_seen, exp_be);
      end
    end
    checks++;
    if (sram_word(w, addr) !== ref_word(w, addr)) begin
      errors++; $display("FAIL memory w=%0d addr=%h: got %h required %h", w, addr, sram_word(w, addr), ref_word(w, addr));
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid[w] !== 1'b0) begin errors++; $display("FAIL consume w=%0d: resp_valid %b required 0", w, resp_valid[w]); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if ({req_ready[w], resp_valid[w], resp_err[w], mem_w_en[w], mem_addr[w], mem_wdata[w], resp_rdata[w]} !== 88'd0) begin
        errors++;
        $display("FAIL reset_state w=%0d: ready=%b valid=%b err=%b wen=%b addr=%h wdata=%h rdata=%h required all 0",
                 w, req_ready[w], resp_valid[w], resp_err[w], mem_w_en[w], mem_addr[w], mem_wdata[w], resp_rdata[w]);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 2'b11) begin errors++; $display("FAIL ready_after_reset: got %b required 11", req_ready); end
  endtask

  task automatic test_word();
    run_op(0, 1'b1, 3'b010, 16'h0010, 32'hDEADBEEF);
    run_op(0, 1'b0, 3'b010, 16'h0010, 32'd0);
  endtask

  task automatic test_byte();
    run_op(0, 1'b1, 3'b000, 16'h0020, 32'h000000F0);
    run_op(0, 1'b0, 3'b000, 16'h0020, 32'd0);
    run_op(0, 1'b0, 3'b100, 16'h0020, 32'd0);
  endtask

  task automatic test_misaligned();
    run_op(0, 1'b1, 3'b001, 16'h0031, 32'h00008001);
    checks++;
    if ({sram[0][16'h0032], sram[0][16'h0031]} !== 16'h8001) begin
      errors++; $display("FAIL sh_misaligned_bytes: got %h required 8001", {sram[0][16'h0032], sram[0][16'h0031]});
    end
    run_op(0, 1'b0, 3'b001, 16'h0031, 32'd0);
    run_op(1, 1'b1, 3'b001, 16'h0031, 32'h00008001);
    run_op(1, 1'b0, 3'b010, 16'h0032, 32'd0);
  endtask

  task automatic test_illegal();
    run_op(0, 1'b0, 3'b011, 16'h0010, 32'd0);
    run_op(0, 1'b1, 3'b100, 16'h0010, 32'h55AA55AA);
    run_op(0, 1'b1, 3'b111, 16'h0014, 32'h12345678);
  endtask

  task automatic test_backpressure();
    logic got;
    run_op(0, 1'b1, 3'b010, 16'h0080, 32'h12345678);
    resp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 16'h0080; req_valid[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); got = req_ready[0];
      @(posedge clk);
    end
    #1 req_valid[0] = 1'b0;
    for (int t = 0; t < 4 && !resp_valid[0]; t++) begin @(posedge clk); #1; end
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h12345678) begin
      errors++; $display("FAIL bp_load: valid=%b rdata=%h required 1 12345678", resp_valid[0], resp_rdata[0]);
    end
    req_funct3 = 3'b100; req_addr = 16'h0083; req_valid[0] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h12345678 || req_ready[0] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: valid=%b rdata=%h ready=%b required 1 12345678 0",
                 c, resp_valid[0], resp_rdata[0], req_ready[0]);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready: got %b required 1", req_ready[0]); end
    @(posedge clk); #1 req_valid[0] = 1'b0;
    checks++;
    if (resp_valid[0] !== 1'b0 || mem_addr[0] !== 16'h0083) begin
      errors++; $display("FAIL b2b_accept: valid=%b addr=%h required 0 0083", resp_valid[0], mem_addr[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid[0] !== 1'b1 || resp_rdata[0] !== 32'h00000012) begin
      errors++; $display("FAIL b2b_resp: valid=%b rdata=%h required 1 00000012", resp_valid[0], resp_rdata[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic got;
    for (int i = 0; i < 4; i++) ref_mem[0][16'h0040 + 16'(i)] = 8'(32'hCAFEF00D >> (8*i));
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 16'h0040; req_wdata = 32'hCAFEF00D;
    req_valid[0] = 1'b1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk); got = req_ready[0];
      @(posedge clk);
    end
    #1 req_valid[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({req_ready[0], resp_valid[0], resp_err[0], mem_w_en[0], mem_addr[0], mem_wdata[0], resp_rdata[0]} !== 88'd0) begin
      errors++;
      $display("FAIL reset_mid_state: ready=%b valid=%b err=%b wen=%b addr=%h wdata=%h rdata=%h required all 0",
               req_ready[0], resp_valid[0], resp_err[0], mem_w_en[0], mem_addr[0], mem_wdata[0], resp_rdata[0]);
    end
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (resp_valid[0] !== 1'b0) begin errors++; $display("FAIL reset_mid_noresp cycle %0d: got %b required 0", c, resp_valid[0]); end
    end
    checks++;
    if (sram_word(0, 16'h0040) !== 32'hCAFEF00D) begin
      errors++; $display("FAIL reset_mid_mem: got %h required cafef00d", sram_word(0, 16'h0040));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wrapped;
    run_op(0, 1'b1, 3'b010, 16'hFFFF, 32'h11223344);
    wrapped = {sram[0][16'h0002], sram[0][16'h0001], sram[0][16'h0000], sram[0][16'hFFFF]};
    checks++;
    if (wrapped !== 32'h11223344) begin errors++; $display("FAIL wrap_bytes: got %h required 11223344", wrapped); end
    run_op(0, 1'b0, 3'b010, 16'hFFFF, 32'd0);
    run_op(1, 1'b0, 3'b010, 16'hFFFF, 32'd0);
  endtask

  task automatic test_random();
    int w;
    logic [15:0] base;
    for (int n = 0; n < 80; n++) begin
      w = int'($urandom_range(0, 1));
      base = ($urandom_range(0, 1) == 0) ? 16'h0200 : 16'hFFFC;
      run_op(w, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             base + 16'($urandom_range(0, 7)), $urandom);
    end
  endtask

  initial begin
    for (int g = 0; g < 2; g++)
      for (int a = 0; a < 65536; a++) ref_mem[g][a] = init_byte(g, a);
    test_reset();
    test_word();
    test_byte();
    test_misaligned();
    test_illegal();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
